// File: rtl/breakout_game_ctrl.sv
// Game sequencer for the breakout datapath: serve timing, miss/clear detection, lives/score/level.
// Optional pause support is compiled in with `define BREAKOUT_PAUSE_EN.
module breakout_game_ctrl #(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MISS_Y       = 470,
  parameter int unsigned SCORE_W      = 12,
  parameter int unsigned NBRICKS      = 9
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               start_key,
  input  logic               pause_key,
  input  logic [9:0]         ball_y,
  input  logic [NBRICKS-1:0] brick_exists,
  output logic               ball_rst,
  output logic               start_ball,
  output logic               ball_hold,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level,
  output logic               game_over,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    CLEAR = 3'd4,
    OVER  = 3'd5,
    PAUSE = 3'd6
  } state_e;

  localparam int unsigned PW      = $clog2(NBRICKS + 1);
  localparam logic [9:0]  MISS_YC = 10'(MISS_Y);
  localparam logic [2:0]  LIVES_C = 3'(LIVES_INIT);
  localparam logic [7:0]  SERVE_C = 8'(SERVE_FRAMES);

  function automatic logic [PW-1:0] popcount(input logic [NBRICKS-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < NBRICKS; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  state_e               state_q, state_d;
  logic [7:0]           serve_cnt_q, serve_cnt_d;
  logic [2:0]           lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [3:0]           level_q, level_d;
  logic                 start_ball_q, start_ball_d;
  logic                 ball_rst_q, game_over_q;
  logic                 start_q;
  logic [NBRICKS-1:0]   brick_q;
  logic                 start_edge;
  logic                 play_checks;
  logic [SCORE_W:0]     score_sum;

  // History registers load the live inputs during reset so no edge appears on release.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      start_q <= start_key;
      brick_q <= brick_exists;
    end else begin
      start_q <= start_key;
      brick_q <= brick_exists;
    end
  end

  assign start_edge = start_key & ~start_q;
  assign score_sum  = {1'b0, score_q} + (SCORE_W+1)'(popcount(brick_q & ~brick_exists));

`ifdef BREAKOUT_PAUSE_EN
  logic pause_q, pause_edge, ball_hold_q;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) pause_q <= pause_key;
    else       pause_q <= pause_key;
  end

  assign pause_edge = pause_key & ~pause_q;
`else
  logic unused_pause;
  assign unused_pause = pause_key;
`endif

  always_comb begin
    state_d      = state_q;
    serve_cnt_d  = serve_cnt_q;
    lives_d      = lives_q;
    score_d      = score_q;
    level_d      = level_q;
    start_ball_d = 1'b0;
    play_checks  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          serve_cnt_d = SERVE_C;
          state_d     = SERVE;
        end
      end
      SERVE: begin
        if (serve_cnt_q == '0) begin
          start_ball_d = 1'b1;
          state_d      = PLAY;
        end else begin
          serve_cnt_d = serve_cnt_q - 8'd1;
        end
      end
      PLAY: begin
        play_checks = 1'b1;
`ifdef BREAKOUT_PAUSE_EN
        if (pause_edge) begin
          play_checks = 1'b0;
          state_d     = PAUSE;
        end
`endif
        // Clear takes priority over a simultaneous miss.
        if (play_checks) begin
          score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          if (brick_exists == '0) begin
            state_d = CLEAR;
            if (level_q != 4'hF) level_d = level_q + 4'd1;
          end else if (ball_y >= MISS_YC) begin
            state_d = MISS;
            if (lives_q != '0) lives_d = lives_q - 3'd1;
          end
        end
      end
      MISS: begin
        if (lives_q == '0) begin
          state_d = OVER;
        end else begin
          serve_cnt_d = SERVE_C;
          state_d     = SERVE;
        end
      end
      CLEAR: begin
        if (start_edge) begin
          serve_cnt_d = SERVE_C;
          state_d     = SERVE;
        end
      end
      OVER: begin
        if (start_edge) begin
          lives_d     = LIVES_C;
          score_d     = '0;
          level_d     = '0;
          serve_cnt_d = SERVE_C;
          state_d     = SERVE;
        end
      end
`ifdef BREAKOUT_PAUSE_EN
      PAUSE: begin
        if (pause_edge) state_d = PLAY;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      serve_cnt_q  <= '0;
      lives_q      <= LIVES_C;
      score_q      <= '0;
      level_q      <= '0;
      start_ball_q <= 1'b0;
      ball_rst_q   <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      serve_cnt_q  <= serve_cnt_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      level_q      <= level_d;
      start_ball_q <= start_ball_d;
      ball_rst_q   <= (state_d == IDLE) || (state_d == MISS) ||
                      (state_d == CLEAR) || (state_d == OVER);
      game_over_q  <= (state_d == OVER);
    end
  end

`ifdef BREAKOUT_PAUSE_EN
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) ball_hold_q <= 1'b0;
    else       ball_hold_q <= (state_d == PAUSE);
  end
  assign ball_hold = ball_hold_q;
`else
  assign ball_hold = 1'b0;
`endif

  assign ball_rst   = ball_rst_q;
  assign start_ball = start_ball_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign level      = level_q;
  assign game_over  = game_over_q;
  assign state      = state_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Randomized + directed bench for breakout_game_ctrl against a rule-level game model.
module tb_breakout_game_ctrl;

`ifdef BREAKOUT_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic        start_key, pause_key;
  logic [9:0]  ball_y;
  logic [8:0]  brick_exists;
  logic        ball_rst, start_ball, ball_hold, game_over;
  logic [2:0]  lives, state;
  logic [11:0] score;
  logic [3:0]  level;

  breakout_game_ctrl #(
    .LIVES_INIT  (3),
    .SERVE_FRAMES(60),
    .MISS_Y      (470),
    .SCORE_W     (12),
    .NBRICKS     (9)
  ) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .start_key   (start_key),
    .pause_key   (pause_key),
    .ball_y      (ball_y),
    .brick_exists(brick_exists),
    .ball_rst    (ball_rst),
    .start_ball  (start_ball),
    .ball_hold   (ball_hold),
    .lives       (lives),
    .score       (score),
    .level       (level),
    .game_over   (game_over),
    .state       (state)
  );

  always #5 frame_clk = ~frame_clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus currently applied
  bit         cur_s, cur_p;
  logic [9:0] cur_y;
  logic [8:0] cur_b;

  // Game model: state numbers are the externally visible codes
  int         m_state, m_lives, m_score, m_level, m_cnt;
  bit         m_sp, m_pp, m_sb;
  logic [8:0] m_bp;

  task automatic model_reset();
    m_state = 0; m_lives = 3; m_score = 0; m_level = 0; m_cnt = 0; m_sb = 0;
    m_sp = cur_s; m_pp = cur_p; m_bp = cur_b;
  endtask

  task automatic model_step();
    bit se, pe;
    int nxt;
    se  = cur_s && !m_sp;
    pe  = cur_p && !m_pp;
    nxt = m_state;
    m_sb = 0;
    case (m_state)
      0: if (se) begin nxt = 1; m_cnt = 60; end
      1: if (m_cnt == 0) begin nxt = 2; m_sb = 1; end else m_cnt = m_cnt - 1;
      2: begin
        if (PAUSE_ON && pe) nxt = 6;
        else begin
          m_score = m_score + $countones(m_bp & ~cur_b);
          if (m_score > 4095) m_score = 4095;
          if (cur_b == 0) begin
            nxt = 4;
            if (m_level < 15) m_level = m_level + 1;
          end else if (cur_y >= 470) begin
            nxt = 3;
            if (m_lives > 0) m_lives = m_lives - 1;
          end
        end
      end
      3: if (m_lives == 0) nxt = 5; else begin nxt = 1; m_cnt = 60; end
      4: if (se) begin nxt = 1; m_cnt = 60; end
      5: if (se) begin nxt = 1; m_cnt = 60; m_lives = 3; m_score = 0; m_level = 0; end
      6: if (pe) nxt = 2;
      default: nxt = 0;
    endcase
    m_state = nxt;
    m_sp = cur_s; m_pp = cur_p; m_bp = cur_b;
  endtask

  task automatic compare_all();
    check("state", 32'(state), m_state);
    check("lives", 32'(lives), m_lives);
    check("score", 32'(score), m_score);
    check("level", 32'(level), m_level);
    check("ball_rst", 32'(ball_rst),
          (m_state == 0 || m_state == 3 || m_state == 4 || m_state == 5) ? 1 : 0);
    check("start_ball", 32'(start_ball), m_sb);
    check("game_over", 32'(game_over), (m_state == 5) ? 1 : 0);
    check("ball_hold", 32'(ball_hold), (m_state == 6) ? 1 : 0);
  endtask

  task automatic drive();
    start_key = cur_s; pause_key = cur_p; ball_y = cur_y; brick_exists = cur_b;
  endtask

  task automatic step();
    @(negedge frame_clk);
    drive();
    model_step();
    @(posedge frame_clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge frame_clk);
    Reset = 1'b1;
    drive();
    #1;
    model_reset();
    compare_all();
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  // Step until start_ball appears; latency 999 means the bound expired
  task automatic run_to_play(output int unsigned lat);
    lat   = 999;
    cur_s = 0;
    for (int unsigned k = 1; k <= 200; k++) begin
      step();
      if (start_ball === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  int unsigned lat;
  int unsigned sc0;
  bit          saw;
  int unsigned r;

  initial begin
    Reset = 1'b1;
    cur_s = 0; cur_p = 0; cur_y = 10'd100; cur_b = 9'h1FF;
    drive();

    // Reset state and first serve latency
    do_reset();
    cur_s = 1; step();
    run_to_play(lat);
    check("serve_latency", lat, 61);

    // Scoring: three bricks lost at once, regrowth not scored, threshold-1 is safe
    sc0 = score;
    cur_b = 9'h1F8; step();
    check("score_plus3", 32'(score), sc0 + 3);
    cur_b = 9'h1FF; step();
    check("score_regrow", 32'(score), sc0 + 3);
    cur_y = 10'd469; step();
    check("y469_no_miss", 32'(state), 2);

    // Three misses to game over
    for (int unsigned i = 0; i < 3; i++) begin
      cur_y = 10'd470; step();
      check("miss_lives", 32'(lives), 2 - i);
      check("miss_ball_rst", 32'(ball_rst), 1);
      cur_y = 10'd100; step();
      if (i < 2) run_to_play(lat);
    end
    check("over_flag", 32'(game_over), 1);

    // Restart from OVER clears the game counters
    cur_s = 1; step();
    check("restart_lives", 32'(lives), 3);
    check("restart_score", 32'(score), 0);
    run_to_play(lat);

    // Clear and miss together: clear wins
    cur_b = 9'h000; cur_y = 10'd475; step();
    check("clear_state", 32'(state), 4);
    check("clear_level", 32'(level), 1);
    check("clear_lives", 32'(lives), 3);
    cur_b = 9'h1FF; cur_y = 10'd100; step();
    cur_s = 1; step();
    check("clear_to_serve", 32'(state), 1);
    cur_s = 0;

    // Reset mid-serve aborts at once and never serves
    for (int unsigned i = 0; i < 5; i++) step();
    do_reset();
    check("reset_async_state", 32'(state), 0);
    saw = 0;
    for (int unsigned i = 0; i < 70; i++) begin
      step();
      if (start_ball === 1'b1) saw = 1;
    end
    check("no_serve_after_reset", 32'(saw), 0);

    // Pause handling
    cur_s = 1; step();
    run_to_play(lat);
    cur_p = 1; step();
`ifdef BREAKOUT_PAUSE_EN
    check("pause_hold", 32'(ball_hold), 1);
`else
    check("hold_tied0", 32'(ball_hold), 0);
`endif
    cur_y = 10'd479; step();
    cur_p = 0; step();
    cur_p = 1; step();
    cur_p = 0; cur_y = 10'd100; step();

    // Randomized play
    for (int unsigned n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) cur_s = ~cur_s;
      if ($urandom_range(0, 14) == 0) cur_p = ~cur_p;
      cur_y = ($urandom_range(0, 49) == 0) ? 10'($urandom_range(470, 1023))
                                          : 10'($urandom_range(0, 469));
      r = $urandom_range(0, 99);
      if (r < 60)      cur_b = cur_b;
      else if (r < 85) cur_b = cur_b & ~(9'd1 << $urandom_range(0, 8));
      else if (r < 92) cur_b = cur_b & 9'($urandom);
      else if (r < 96) cur_b = 9'($urandom);
      else if (r < 98) cur_b = 9'h1FF;
      else             cur_b = 9'h000;
      step();
    end

    // Saturation of score and level over many clears
    cur_s = 0; cur_p = 0; cur_y = 10'd100; cur_b = 9'h1FF;
    do_reset();
    cur_s = 1; step();
    run_to_play(lat);
    for (int unsigned i = 0; i < 460; i++) begin
      cur_b = 9'h000; step();
      cur_b = 9'h1FF; step();
      cur_s = 1; step();
      run_to_play(lat);
    end
    check("score_saturated", 32'(score), 4095);
    check("level_saturated", 32'(level), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
